// File: rtl/fp_normalizer.sv
// Normalize / round / pack stage for the single-precision datapath.
// Takes a raw {sign, exponent, 28-bit mantissa} from the mantissa adder,
// left-shifts one bit per cycle until the hidden bit is set (or the exponent
// bottoms out), rounds to nearest-even in one cycle and packs an IEEE-754
// single together with overflow/underflow/inexact flags.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [27:0] mantis,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        s_r;
  logic [8:0]  e_r;
  logic [27:0] m_r;
  logic        nz_r;

  // Round-to-nearest-even on bits [27:3]; bit 24 of the sum is the carry out
  // of the hidden-bit position.
  function automatic logic [24:0] round_rne(input logic [27:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return m[27:3] + {24'd0, up};
  endfunction

  // Post-round renormalize and pack. Returns {result, overflow, underflow, inexact}.
  // The exponent is 9 bits so a carry past 254 is still visible for saturation.
  function automatic logic [34:0] pack(input logic s, input logic [8:0] e,
                                       input logic [24:0] rnd, input logic nz,
                                       input logic ix);
    logic        carry;
    logic [8:0]  ef;
    logic        hid;
    logic [22:0] frac;
    carry = rnd[24];
    ef    = e + {8'd0, carry};
    hid   = carry | rnd[23];
    frac  = carry ? rnd[23:1] : rnd[22:0];
    if (ef >= 9'd255)
      return {s, 8'hFF, 23'd0, 1'b1, 1'b0, ix};
    else if (!hid)
      return {s, 8'h00, frac, 1'b0, nz, ix};
    else
      return {s, ef[7:0], frac, 1'b0, 1'b0, ix};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control: FSM sequencing plus the registered result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= NORM;
        end
        NORM: begin
          if (m_r[27] || (m_r == 28'd0) || m_r[26] || (e_r <= 9'd1))
            state <= ROUND;
        end
        ROUND: begin
          {result, overflow, underflow, inexact} <=
            pack(s_r, e_r, round_rne(m_r), nz_r, |m_r[2:0]);
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture and the one-bit-per-cycle normalize shift.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      s_r  <= sign;
      e_r  <= (exp == 8'd0) ? 9'd1 : {1'b0, exp};
      m_r  <= mantis;
      nz_r <= |mantis;
    end else if (state == NORM) begin
      if (m_r[27]) begin
        // Carry out of the adder: one right shift, folding the lost bit into sticky.
        m_r <= {1'b0, m_r[27:2], m_r[1] | m_r[0]};
        e_r <= e_r + 9'd1;
      end else if (!((m_r == 28'd0) || m_r[26] || (e_r <= 9'd1))) begin
        m_r <= {m_r[26:0], 1'b0};
        e_r <= e_r - 9'd1;
      end
    end
  end

endmodule
